// File: rtl/stereo_pkg.sv
// -----------------------------------------------------------------------------
// stereo_pkg
// Shared types and constants for the stereo disparity pipeline.
//   arb_state_t   : previous-cycle grant recorded by the BRAM arbiter
//   DISP_ADDR_W   : disparity BRAM address width (320*240 = 76800 words)
//   DISP_DATA_W   : disparity word width
//   IMG_W / IMG_H : image geometry as used by the address generators
//   sat_inc16     : saturating 16-bit increment for statistics counters
// -----------------------------------------------------------------------------
package stereo_pkg;

    localparam int DISP_ADDR_W = 17;
    localparam int DISP_DATA_W = 8;
    localparam int IMG_W       = 240;
    localparam int IMG_H       = 320;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RD,
        ARB_WR
    } arb_state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/arb_valid_pipe.sv
// -----------------------------------------------------------------------------
// arb_valid_pipe
// DEPTH-stage shift register that delays a single-bit strobe by DEPTH cycles.
// The asynchronous clear empties every stage, so strobes in flight at reset
// never reach the output.
// Ports:
//   clk_100mhz : system clock
//   sys_rst_n  : asynchronous active-low clear
//   pulse      : strobe entering the pipe
//   delayed    : strobe leaving the pipe, DEPTH cycles later
// -----------------------------------------------------------------------------
module arb_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk_100mhz,
    input  logic sys_rst_n,
    input  logic pulse,
    output logic delayed
);

    logic [DEPTH-1:0] stage;

    // Plain shift register; stage[0] is the newest entry.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= pulse;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/disparity_bram_arbiter.sv
// -----------------------------------------------------------------------------
// disparity_bram_arbiter
// Shares the single-port disparity result BRAM between the stereo-match
// writer and the display readout. One access is granted per cycle; the BRAM
// port is driven from registers one cycle after the grant, and read data is
// returned with a valid strobe 1+RD_LATENCY cycles after the read grant.
// Reads win contention until a pending write has lost STARVE_LIMIT times in a
// row, after which the write is forced through.
//
// Optional feature: define ARB_STATS_EN to build the saturating statistics
// counters; without it stat_wr_stall and stat_rd_count are tied to zero.
//
// Ports:
//   clk_100mhz, sys_rst_n     : clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data    : write request (held until wr_gnt)
//   wr_gnt                    : write accepted this cycle
//   rd_req/rd_addr            : read request (held until rd_gnt)
//   rd_gnt                    : read accepted this cycle
//   rd_valid/rd_data          : in-order read return
//   mem_addr/mem_we/mem_din   : registered BRAM port drive
//   mem_dout                  : BRAM read data
//   stat_wr_stall             : cycles with wr_req && !wr_gnt (saturating)
//   stat_rd_count             : read grants (saturating)
// -----------------------------------------------------------------------------
module disparity_bram_arbiter
    import stereo_pkg::*;
#(
    parameter int ADDR_W       = DISP_ADDR_W,
    parameter int DATA_W       = DISP_DATA_W,
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_100mhz,
    input  logic              sys_rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [15:0]       stat_wr_stall,
    output logic [15:0]       stat_rd_count
);

    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state;
    arb_state_t          state_next;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_next;
    logic                writer_forced;

    // Arbitration and next-state. Grants are held low while reset is asserted
    // so nothing is accepted that the cleared pipeline would then lose.
    always_comb begin
        rd_gnt        = 1'b0;
        wr_gnt        = 1'b0;
        state_next    = ARB_IDLE;
        starve_next   = starve_cnt;
        writer_forced = (starve_cnt == STARVE_MAX);

        if (sys_rst_n) begin
            if (rd_req && !(wr_req && writer_forced)) begin
                rd_gnt = 1'b1;
            end else if (wr_req) begin
                wr_gnt = 1'b1;
            end
        end

        if (rd_gnt) begin
            state_next = ARB_RD;
        end else if (wr_gnt) begin
            state_next = ARB_WR;
        end

        if (!wr_req || wr_gnt) begin
            starve_next = '0;
        end else if (!writer_forced) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // State register records last cycle's grant; starvation counter alongside.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // The write enable is exactly "last cycle granted a write", which is what
    // the state register already holds. Address/data only move on a grant, so
    // the BRAM sees a stable port on idle cycles.
    assign mem_we = (state == ARB_WR);

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (wr_gnt) begin
            mem_addr <= wr_addr;
            mem_din  <= wr_data;
        end else if (rd_gnt) begin
            mem_addr <= rd_addr;
        end
    end

    // One register stage for the port drive plus the BRAM's own latency.
    arb_valid_pipe #(
        .DEPTH(1 + RD_LATENCY)
    ) u_valid_pipe (
        .clk_100mhz(clk_100mhz),
        .sys_rst_n (sys_rst_n),
        .pulse     (rd_gnt),
        .delayed   (rd_valid)
    );

    assign rd_data = rd_valid ? mem_dout : '0;

`ifdef ARB_STATS_EN
    logic [15:0] wr_stall_cnt;
    logic [15:0] rd_grant_cnt;

    // Saturating statistics for bandwidth tuning of the two requesters.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_stall_cnt <= '0;
            rd_grant_cnt <= '0;
        end else begin
            if (wr_req && !wr_gnt) begin
                wr_stall_cnt <= sat_inc16(wr_stall_cnt);
            end
            if (rd_gnt) begin
                rd_grant_cnt <= sat_inc16(rd_grant_cnt);
            end
        end
    end

    assign stat_wr_stall = wr_stall_cnt;
    assign stat_rd_count = rd_grant_cnt;
`else
    assign stat_wr_stall = 16'h0;
    assign stat_rd_count = 16'h0;
`endif

endmodule

// File: tb/tb_disparity_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_disparity_bram_arbiter
// Directed and randomized stimulus for the disparity BRAM arbiter, checked
// against a transaction-level model: grants follow the priority rules, every
// accepted write lands in a shadow memory at once, and every accepted read
// expects the shadow contents three cycles later. A behavioural BRAM with two
// cycles of read latency sits on the memory port.
// -----------------------------------------------------------------------------
module tb_disparity_bram_arbiter;

    localparam int ADDR_W       = 17;
    localparam int DATA_W       = 8;
    localparam int STARVE_LIMIT = 4;
    localparam int DEPTH_WORDS  = 76800;
    localparam int RD_DELAY     = 3;

`ifdef ARB_STATS_EN
    localparam int STALL_RUN_CYCLES = 82000;
`else
    localparam int STALL_RUN_CYCLES = 300;
`endif

    logic              clk_100mhz = 1'b0;
    logic              sys_rst_n;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic [15:0]       stat_wr_stall;
    logic [15:0]       stat_rd_count;

    always #5 clk_100mhz = ~clk_100mhz;

    disparity_bram_arbiter dut (
        .clk_100mhz   (clk_100mhz),
        .sys_rst_n    (sys_rst_n),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_gnt       (wr_gnt),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .stat_wr_stall(stat_wr_stall),
        .stat_rd_count(stat_rd_count)
    );

    // Behavioural single-port BRAM, read-first, output register enabled.
    logic [DATA_W-1:0] bram [0:DEPTH_WORDS-1];
    logic [DATA_W-1:0] bram_stage;

    always @(posedge clk_100mhz) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        bram_stage <= bram[mem_addr];
        mem_dout   <= bram_stage;
    end

    // Reference model state.
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rd_expect_t;

    logic [DATA_W-1:0] shadow [0:DEPTH_WORDS-1];
    rd_expect_t        exp_q [$];
    int                m_starve;
    int                m_stall;
    int                m_rdcnt;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;
    logic              exp_rd_gnt;
    logic              exp_wr_gnt;
    int                cycle;
    int                checks;
    int                passes;
    int                valid_seen;
    int                wr_gnt_seen;
    int                first_wr_cycle;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic wq, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd, input logic rq,
                                 input logic [ADDR_W-1:0] ra);
        wr_req  = wq;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = rq;
        rd_addr = ra;
    endtask

    task automatic clearModel();
        m_starve = 0;
        m_stall  = 0;
        m_rdcnt  = 0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_din    = '0;
        exp_q.delete();
    endtask

    // Compare one cycle of DUT outputs with the model, then advance the model.
    task automatic checkCycle();
        logic in_reset;
        in_reset   = !sys_rst_n;
        exp_rd_gnt = !in_reset && rd_req && !(wr_req && m_starve == STARVE_LIMIT);
        exp_wr_gnt = !in_reset && wr_req && !exp_rd_gnt;

        checkOutput("rd_gnt", 32'(rd_gnt), 32'(exp_rd_gnt));
        checkOutput("wr_gnt", 32'(wr_gnt), 32'(exp_wr_gnt));
        checkOutput("mem_we", 32'(mem_we), 32'(m_we));
        checkOutput("mem_addr", 32'(mem_addr), 32'(m_addr));
        checkOutput("mem_din", 32'(mem_din), 32'(m_din));

        if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
            checkOutput("rd_valid", 32'(rd_valid), 32'd1);
            checkOutput("rd_data", 32'(rd_data), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
        end else begin
            checkOutput("rd_valid_idle", 32'(rd_valid), 32'd0);
        end
        if (in_reset) checkOutput("rd_data_reset", 32'(rd_data), 32'd0);

`ifdef ARB_STATS_EN
        checkOutput("stat_wr_stall", 32'(stat_wr_stall), 32'(m_stall));
        checkOutput("stat_rd_count", 32'(stat_rd_count), 32'(m_rdcnt));
`else
        checkOutput("stat_wr_stall", 32'(stat_wr_stall), 32'd0);
        checkOutput("stat_rd_count", 32'(stat_rd_count), 32'd0);
`endif

        if (rd_valid === 1'b1) valid_seen++;
        if (wr_gnt === 1'b1) begin
            wr_gnt_seen++;
            if (first_wr_cycle < 0) first_wr_cycle = cycle;
        end

        if (!in_reset) begin
            if (exp_wr_gnt) begin
                shadow[wr_addr] = wr_data;
                m_we   = 1'b1;
                m_addr = wr_addr;
                m_din  = wr_data;
            end else begin
                m_we = 1'b0;
                if (exp_rd_gnt) m_addr = rd_addr;
            end
            if (exp_rd_gnt) begin
                exp_q.push_back('{cycle + RD_DELAY, shadow[rd_addr]});
                if (m_rdcnt < 65535) m_rdcnt++;
            end
            if (wr_req && !exp_wr_gnt) begin
                if (m_starve < STARVE_LIMIT) m_starve++;
                if (m_stall < 65535) m_stall++;
            end else begin
                m_starve = 0;
            end
        end
        cycle++;
    endtask

    task automatic step();
        @(negedge clk_100mhz);
        checkCycle();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rd_gnt"}, 32'(rd_gnt), 32'd0);
        checkOutput({tag, "_wr_gnt"}, 32'(wr_gnt), 32'd0);
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_mem_din"}, 32'(mem_din), 32'd0);
        checkOutput({tag, "_stat_wr_stall"}, 32'(stat_wr_stall), 32'd0);
        checkOutput({tag, "_stat_rd_count"}, 32'(stat_rd_count), 32'd0);
    endtask

    // Random requesters: hold a pending request until the model grants it,
    // occasionally withdrawing it, otherwise issue a fresh one.
    task automatic randomRequests(input int addr_max);
        if (!(wr_req && !exp_wr_gnt && $urandom_range(0, 9) != 0)) begin
            wr_req  = 1'($urandom_range(0, 1));
            wr_addr = ADDR_W'($urandom_range(0, addr_max));
            wr_data = DATA_W'($urandom);
        end
        if (!(rd_req && !exp_rd_gnt && $urandom_range(0, 9) != 0)) begin
            rd_req  = 1'($urandom_range(0, 1));
            rd_addr = ADDR_W'($urandom_range(0, addr_max));
        end
    endtask

    initial begin
        int base;
        checks         = 0;
        passes         = 0;
        cycle          = 0;
        valid_seen     = 0;
        wr_gnt_seen    = 0;
        first_wr_cycle = -1;
        exp_rd_gnt     = 1'b0;
        exp_wr_gnt     = 1'b0;
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            bram[i]   = DATA_W'($urandom);
            shadow[i] = bram[i];
        end
        clearModel();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);

        // Power-up reset.
        sys_rst_n = 1'b0;
        #1;
        checkResetOutputs("por");
        step();
        step();
        sys_rst_n = 1'b1;
        step();

        // Reset mid-read: the granted read at address 5 must never return.
        $display("[TB] reset during an in-flight read");
        applyStimulus(1'b0, '0, '0, 1'b1, 17'd5);
        step();
        sys_rst_n = 1'b0;
        #1;
        checkResetOutputs("midrd");
        clearModel();
        valid_seen = 0;
        step();
        step();
        sys_rst_n = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 6; i++) step();
        checkOutput("midrd_no_valid", 32'(valid_seen), 32'd0);

        // Single write then read-back of the same address.
        $display("[TB] write then read address 100");
        applyStimulus(1'b1, 17'd100, 8'h2A, 1'b0, '0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 17'd100);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step();

        // Contention: reads every cycle, one write waiting.
        $display("[TB] read/write contention");
        first_wr_cycle = -1;
        base = cycle;
        applyStimulus(1'b1, 17'd200, 8'h5C, 1'b1, 17'd300);
        for (int i = 0; i < 10; i++) begin
            step();
            if (exp_wr_gnt) wr_req = 1'b0;
            if (exp_rd_gnt) rd_addr = rd_addr + 17'd1;
        end
        checkOutput("contention_wr_gnt_cycle", 32'(first_wr_cycle - base), 32'd4);
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step();

        // Streaming reads at addresses 0..9.
        $display("[TB] streaming reads");
        valid_seen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, ADDR_W'(i));
            step();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("stream_valid_count", 32'(valid_seen), 32'd10);

        // Writer alone: 240 back-to-back writes.
        $display("[TB] writer alone");
        wr_gnt_seen = 0;
        for (int i = 0; i < 240; i++) begin
            applyStimulus(1'b1, ADDR_W'(1000 + i), DATA_W'($urandom), 1'b0, '0);
            step();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        step();
        checkOutput("writer_gnt_count", 32'(wr_gnt_seen), 32'd240);

        // Randomized mix on a small address window to provoke RAW hazards.
        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            randomRequests(15);
            step();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step();

        // Long forced-stall run for counter saturation.
        $display("[TB] sustained contention, %0d cycles", STALL_RUN_CYCLES);
        applyStimulus(1'b1, 17'd7, 8'h11, 1'b1, 17'd9);
        for (int i = 0; i < STALL_RUN_CYCLES; i++) begin
            step();
            if (exp_wr_gnt) begin
                wr_addr = ADDR_W'($urandom_range(0, 63));
                wr_data = DATA_W'($urandom);
            end
            if (exp_rd_gnt) rd_addr = ADDR_W'($urandom_range(0, 63));
        end
`ifdef ARB_STATS_EN
        checkOutput("stall_saturated", 32'(stat_wr_stall), 32'h0000FFFF);
`else
        checkOutput("stall_disabled", 32'(stat_wr_stall), 32'd0);
`endif
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("drained_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
